// File: rtl/bitonic_pkg.sv
// Shared types, layer schedule and index helpers for the serial bitonic sorter.
// SORT_ASCEND_EN: when defined, every compare direction flips and output is smallest first.
package bitonic_pkg;

  localparam int NUM    = 8;
  localparam int LAYERS = 6;
  localparam int CAS_N  = 4;

  typedef enum logic [1:0] {
    LOAD,
    SORT,
    DRAIN
  } state_t;

  // Layer table, entry 0 in the low nibble:
  // (k,j) = (2,1),(4,2),(4,1),(8,4),(8,2),(8,1)
  localparam logic [LAYERS-1:0][3:0] K_TAB =
    {4'd8, 4'd8, 4'd8, 4'd4, 4'd4, 4'd2};
  localparam logic [LAYERS-1:0][3:0] J_TAB =
    {4'd1, 4'd2, 4'd4, 4'd1, 4'd2, 4'd1};

  function automatic logic [2:0] partner(
    input logic [2:0] i,
    input logic [3:0] j
  );
    return i ^ j[2:0];
  endfunction

  // Lower index of the u-th pair: insert a 0 at bit log2(j) of u.
  function automatic logic [2:0] first_idx(
    input logic [1:0] u,
    input logic [3:0] j
  );
    logic [2:0] m;
    logic [2:0] uu;
    m  = j[2:0] - 3'd1;
    uu = {1'b0, u};
    return ((uu & ~m) << 1) | (uu & m);
  endfunction

  // 1 = place the larger value at the lower index.
  function automatic logic dir(
    input logic [2:0] i,
    input logic [3:0] k
  );
`ifdef SORT_ASCEND_EN
    return (({1'b0, i} & k) != 4'd0);
`else
    return (({1'b0, i} & k) == 4'd0);
`endif
  endfunction

endpackage

// File: rtl/bitonic_cas.sv
// Combinational compare-and-swap for one bitonic pair.
// Equal operands never swap; i_desc puts the larger value on o_a.
module bitonic_cas #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_desc,
  output logic [WIDTH-1:0] o_a,
  output logic [WIDTH-1:0] o_b
);

  logic w_swap;

  assign w_swap = i_desc ? (i_a < i_b) : (i_a > i_b);
  assign o_a    = w_swap ? i_b : i_a;
  assign o_b    = w_swap ? i_a : i_b;

endmodule

// File: rtl/bitonic_stream_sorter.sv
// Serial 8-value bitonic sorter: load 8, sort over 6 layers, drain 8.
// Direction set by SORT_ASCEND_EN (see bitonic_pkg).
module bitonic_stream_sorter
  import bitonic_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy
);

  state_t           r_state;
  logic [WIDTH-1:0] r_buf [NUM];
  logic [2:0]       r_ld_cnt;
  logic [2:0]       r_dr_cnt;
  logic [2:0]       r_layer;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_last;

  logic [3:0]       w_k;
  logic [3:0]       w_j;
  logic [2:0]       w_idx_i [CAS_N];
  logic [2:0]       w_idx_l [CAS_N];
  logic [WIDTH-1:0] w_res_a [CAS_N];
  logic [WIDTH-1:0] w_res_b [CAS_N];
  logic [WIDTH-1:0] w_nbuf  [NUM];

  assign w_k = K_TAB[r_layer];
  assign w_j = J_TAB[r_layer];

  for (genvar u = 0; u < CAS_N; u++) begin : g_cas
    logic w_desc;
    assign w_idx_i[u] = first_idx(2'(u), w_j);
    assign w_idx_l[u] = partner(w_idx_i[u], w_j);
    assign w_desc     = dir(w_idx_i[u], w_k);
    bitonic_cas #(.WIDTH(WIDTH)) u_cas (
      .i_a    (r_buf[w_idx_i[u]]),
      .i_b    (r_buf[w_idx_l[u]]),
      .i_desc (w_desc),
      .o_a    (w_res_a[u]),
      .o_b    (w_res_b[u])
    );
  end

  // Buffer after applying the current layer's four exchanges.
  always_comb begin
    w_nbuf = r_buf;
    for (int u = 0; u < CAS_N; u++) begin
      w_nbuf[w_idx_i[u]] = w_res_a[u];
      w_nbuf[w_idx_l[u]] = w_res_b[u];
    end
  end

  // Load / sort / drain sequencer with registered output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= LOAD;
      r_ld_cnt    <= '0;
      r_dr_cnt    <= '0;
      r_layer     <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      for (int n = 0; n < NUM; n++) r_buf[n] <= '0;
    end else begin
      unique case (r_state)
        LOAD: begin
          if (in_valid) begin
            r_buf[r_ld_cnt] <= in_data;
            r_ld_cnt        <= r_ld_cnt + 3'd1;
            if (r_ld_cnt == 3'd7) begin
              r_state <= SORT;
              r_layer <= '0;
            end
          end
        end
        SORT: begin
          for (int n = 0; n < NUM; n++) r_buf[n] <= w_nbuf[n];
          r_layer <= r_layer + 3'd1;
          if (r_layer == 3'd5) begin
            r_state     <= DRAIN;
            r_layer     <= '0;
            r_dr_cnt    <= '0;
            r_out_valid <= 1'b1;
            r_out_data  <= w_nbuf[0];
            r_out_last  <= 1'b0;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (r_dr_cnt == 3'd7) begin
              r_state     <= LOAD;
              r_dr_cnt    <= '0;
              r_out_valid <= 1'b0;
              r_out_data  <= '0;
              r_out_last  <= 1'b0;
            end else begin
              r_dr_cnt   <= r_dr_cnt + 3'd1;
              r_out_data <= r_buf[r_dr_cnt + 3'd1];
              r_out_last <= (r_dr_cnt == 3'd6);
            end
          end
        end
        default: r_state <= LOAD;
      endcase
    end
  end

  assign in_ready  = (r_state == LOAD);
  assign busy      = (r_state != LOAD);
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;

endmodule

// File: tb/tb_bitonic_stream_sorter.sv
// Directed bench for bitonic_stream_sorter.
// Expected order follows SORT_ASCEND_EN when defined.
module tb_bitonic_stream_sorter;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic       busy;

  int n_chk  = 0;
  int n_pass = 0;

  bitonic_stream_sorter #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(
    input logic [7:0] v [8],
    input bit         hold,
    input bit         gap
  );
    for (int i = 0; i < 8; i++) begin
      if (gap && i == 3) begin
        in_valid = 1'b0;
        in_data  = 8'h77;
        step();
      end
      in_valid = 1'b1;
      in_data  = v[i];
      chk("in_ready_load", in_ready, 1);
      step();
    end
    in_valid = hold;
    in_data  = 8'hEE;
  endtask

  task automatic latency(input string tag);
    int n;
    n = 0;
    chk({tag, "_rdy_sort"}, in_ready, 0);
    chk({tag, "_busy_sort"}, busy, 1);
    while (out_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_latency"}, n, 6);
  endtask

  // exp holds the descending order; mode 1 toggles ready 1,0,0,1
  task automatic drain(
    input string      tag,
    input logic [7:0] exp [8],
    input int         mode
  );
    int idx;
    int cyc;
    logic [7:0] e;
    idx = 0;
    cyc = 0;
    while (idx < 8 && cyc < 100) begin
`ifdef SORT_ASCEND_EN
      e = exp[7-idx];
`else
      e = exp[idx];
`endif
      chk({tag, "_valid"}, out_valid, 1);
      chk({tag, "_data"}, out_data, e);
      chk({tag, "_last"}, out_last, (idx == 7) ? 1 : 0);
      chk({tag, "_rdy_drain"}, in_ready, 0);
      out_ready = (mode == 0) || (cyc % 4 == 0) || (cyc % 4 == 3);
      step();
      if (out_ready) idx++;
      cyc++;
    end
    chk({tag, "_count"}, idx, 8);
    out_ready = 1'b0;
    chk({tag, "_valid_end"}, out_valid, 0);
    chk({tag, "_rdy_end"}, in_ready, 1);
    chk({tag, "_busy_end"}, busy, 0);
  endtask

  initial begin
    logic [7:0] a [8];
    logic [7:0] e [8];
    int         hi;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    #12;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_last", out_last, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    step();
    chk("rst_in_ready", in_ready, 1);

    // batch 1: ascending input
    a = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    e = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    load(a, 1'b0, 1'b0);
    latency("b1");
    drain("b1", e, 0);

    // batch 2: duplicates and extremes, with an idle input cycle
    a = '{8'd5, 8'd5, 8'd0, 8'd255, 8'd5, 8'd0, 8'd255, 8'd1};
    e = '{8'd255, 8'd255, 8'd5, 8'd5, 8'd5, 8'd1, 8'd0, 8'd0};
    load(a, 1'b0, 1'b1);
    latency("b2");
    drain("b2", e, 0);

    // batch 3: interleaved input, stalled drain
    a = '{8'd8, 8'd1, 8'd7, 8'd2, 8'd6, 8'd3, 8'd5, 8'd4};
    e = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    load(a, 1'b0, 1'b0);
    latency("b3");
    drain("b3", e, 1);

    // reset during layer 3
    a = '{8'd9, 8'd200, 8'd3, 8'd4, 8'd50, 8'd6, 8'd7, 8'd1};
    load(a, 1'b0, 1'b0);
    step();
    step();
    step();
    rst_n = 1'b0;
    #2;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    rst_n = 1'b1;
    hi = 0;
    for (int c = 0; c < 10; c++) begin
      if (out_valid !== 1'b0) hi++;
      step();
    end
    chk("mid_rst_no_out", hi, 0);
    chk("mid_rst_ready", in_ready, 1);
    a = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    e = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    load(a, 1'b0, 1'b0);
    latency("b4");
    drain("b4", e, 0);

    // back-to-back with in_valid held high
    a = '{8'd10, 8'd40, 8'd30, 8'd20, 8'd70, 8'd60, 8'd50, 8'd80};
    e = '{8'd80, 8'd70, 8'd60, 8'd50, 8'd40, 8'd30, 8'd20, 8'd10};
    load(a, 1'b1, 1'b0);
    latency("b5");
    drain("b5", e, 0);
    a = '{8'd3, 8'd3, 8'd9, 8'd0, 8'd128, 8'd127, 8'd1, 8'd254};
    e = '{8'd254, 8'd128, 8'd127, 8'd9, 8'd3, 8'd3, 8'd1, 8'd0};
    load(a, 1'b0, 1'b0);
    latency("b6");
    drain("b6", e, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
